// File: rtl/cmd_pkg.sv
// Shared types and constants for the UART command bridge.
package cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_STROBE,
        RD_LATCH,
        TX_SEND,
        TX_GAP,
        TX_WAIT
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam logic [7:0] ACK_BYTE_DEFAULT = 8'h06;

endpackage

// File: rtl/uart_cmd_bridge_if.sv
// UART byte handshakes plus register-bus signals of the command bridge.
interface uart_cmd_bridge_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy;
    logic        we;
    logic [6:0]  addr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        timeout;

    // Bridge side
    modport master (
        input  rx_data, rx_valid, tx_busy, rdat,
        output rx_ack, tx_data, tx_send, we, addr, wdat, timeout
    );

    // UART / register-file side
    modport slave (
        output rx_data, rx_valid, tx_busy, rdat,
        input  rx_ack, tx_data, tx_send, we, addr, wdat, timeout
    );

endinterface

// File: rtl/uart_cmd_bridge.sv
// Byte-protocol to register-bus bridge: {op,addr} command byte, 4-byte
// MSB-first write payload or 4-byte MSB-first read reply, ACK after writes,
// inter-byte timeout on partial writes.
module uart_cmd_bridge
    import cmd_pkg::*;
#(
    parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEFAULT,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1200000
) (
    input  logic              clk12,
    input  logic              rst,
    uart_cmd_bridge_if.master bus
);

    state_t      state;
    logic [31:0] shift;
    logic [1:0]  count;
    logic [23:0] tmo_cnt;
    logic        capture;

    // A byte is taken only while waiting for a command or write payload;
    // otherwise it stays pending in uart_rx.
    assign capture    = bus.rx_valid && !rst && (state == IDLE || state == WR_DATA);
    assign bus.rx_ack = capture;

    // Command framing, write strobe, timeout and TX pacing.
    always_ff @(posedge clk12) begin
        if (rst) begin
            state       <= IDLE;
            shift       <= '0;
            count       <= '0;
            tmo_cnt     <= '0;
            bus.tx_data <= '0;
            bus.tx_send <= 1'b0;
            bus.we      <= 1'b0;
            bus.addr    <= '0;
            bus.wdat    <= '0;
            bus.timeout <= 1'b0;
        end else begin
            bus.we      <= 1'b0;
            bus.tx_send <= 1'b0;
            bus.timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        bus.addr <= bus.rx_data[6:0];
                        count    <= '0;
                        tmo_cnt  <= '0;
                        state    <= (bus.rx_data[7] == OP_WRITE) ? WR_DATA : RD_LATCH;
                    end
                end
                WR_DATA: begin
                    // A byte arriving on the expiry cycle wins over the timeout.
                    if (capture) begin
                        bus.wdat <= {bus.wdat[23:0], bus.rx_data};
                        tmo_cnt  <= '0;
                        count    <= count + 2'd1;
                        if (count == 2'd3) begin
                            bus.we <= 1'b1;
                            state  <= WR_STROBE;
                        end
                    end else if (tmo_cnt == TIMEOUT_CYCLES - 24'd1) begin
                        tmo_cnt     <= '0;
                        bus.timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 24'd1;
                    end
                end
                WR_STROBE: begin
                    shift <= {ACK_BYTE, 24'h0};
                    count <= 2'd0;
                    state <= TX_SEND;
                end
                RD_LATCH: begin
                    shift <= bus.rdat;
                    count <= 2'd3;
                    state <= TX_SEND;
                end
                TX_SEND: begin
                    if (!bus.tx_busy) begin
                        bus.tx_data <= shift[31:24];
                        bus.tx_send <= 1'b1;
                        state       <= TX_GAP;
                    end
                end
                TX_GAP: begin
                    // uart_tx has not raised busy yet; skip one sample.
                    state <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (!bus.tx_busy) begin
                        if (count == 2'd0) begin
                            state <= IDLE;
                        end else begin
                            shift <= {shift[23:0], 8'h00};
                            count <= count - 2'd1;
                            state <= TX_SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Self-checking bench for uart_cmd_bridge: uart_rx/uart_tx/register-file
// models, a table of directed commands, multi-cycle corner sequences and a
// randomized command stream checked against a transaction-level model.
module tb_uart_cmd_bridge;

    localparam int unsigned TMO = 100;

    logic clk12 = 1'b0;
    logic rst   = 1'b1;

    always #5 clk12 = ~clk12;

    uart_cmd_bridge_if bus ();

    uart_cmd_bridge #(
        .ACK_BYTE       (8'h06),
        .TIMEOUT_CYCLES (24'd100)
    ) dut (
        .clk12 (clk12),
        .rst   (rst),
        .bus   (bus.master)
    );

    int compared   = 0;
    int mismatched = 0;

    int unsigned cyc          = 0;
    int unsigned last_ack_cyc = 0;
    int unsigned timeout_cyc  = 0;
    int unsigned ack_cnt      = 0;
    int unsigned send_cnt     = 0;
    int unsigned timeout_cnt  = 0;

    logic [7:0]  rxq[$];
    logic [7:0]  txlog[$];
    logic [38:0] welog[$];

    logic [31:0] tmp32     = '0;
    logic [31:0] model_tmp = '0;
    logic        hold_busy = 1'b0;
    logic        start_pending = 1'b0;
    int          busy_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register file: 7F holds tmp32, 0F reads tmp32+FF, everything else unmapped.
    always_comb begin
        case (bus.addr)
            7'h7F:   bus.rdat = tmp32;
            7'h0F:   bus.rdat = tmp32 + 32'hFF;
            default: bus.rdat = 32'hDEADC0DE;
        endcase
    end

    // Register file write port.
    always @(posedge clk12) begin
        if (bus.we && bus.addr == 7'h7F) tmp32 <= bus.wdat;
    end

    // uart_rx consume side: pop on the acknowledged edge.
    always @(posedge clk12) begin
        cyc++;
        if (bus.rx_ack) begin
            ack_cnt++;
            last_ack_cyc = cyc;
            if (rxq.size() != 0) void'(rxq.pop_front());
        end
    end

    // uart_rx present side: head of queue held until consumed.
    always @(negedge clk12) begin
        bus.rx_valid = (rxq.size() != 0);
        bus.rx_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
    end

    // uart_tx model and output monitor, sampled mid-cycle.
    always @(negedge clk12) begin
        if (bus.tx_send) begin
            send_cnt++;
            check("tx_send_while_busy", {63'd0, bus.tx_busy | start_pending}, 64'd0);
            txlog.push_back(bus.tx_data);
        end
        if (start_pending) begin
            busy_left     = 3 + int'($urandom_range(0, 20));
            start_pending = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        if (bus.tx_send) start_pending = 1'b1;
        bus.tx_busy = (busy_left > 0) || hold_busy;
        if (bus.we) welog.push_back({bus.addr, bus.wdat});
        if (bus.timeout) begin
            timeout_cnt++;
            timeout_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk12);
        #2;
    endtask

    task automatic clear_logs();
        txlog.delete();
        welog.delete();
    endtask

    task automatic push_cmd(input logic [7:0] cmd, input logic [31:0] data);
        rxq.push_back(cmd);
        if (cmd[7]) begin
            for (int b = 3; b >= 0; b--) rxq.push_back(data[b*8 +: 8]);
        end
    endtask

    task automatic wait_tx(input int n, input int budget, input string name);
        int k = 0;
        while (txlog.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, txlog.size(), n);
    endtask

    task automatic settle();
        int k = 0;
        while ((bus.tx_busy || start_pending || rxq.size() != 0) && k < 3000) begin
            tick();
            k++;
        end
        check("settle", {63'd0, k < 3000}, 64'd1);
        repeat (4) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ack"},  bus.rx_ack,  0);
        check({tag, "_tx_send"}, bus.tx_send, 0);
        check({tag, "_we"},      bus.we,      0);
        check({tag, "_timeout"}, bus.timeout, 0);
        check({tag, "_tx_data"}, bus.tx_data, 0);
        check({tag, "_addr"},    bus.addr,    0);
        check({tag, "_wdat"},    bus.wdat,    0);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] data;
        int          ntx;
        logic [31:0] exp_tx;
        bit          is_wr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [31:0] t;
        logic [7:0]  exp_q[$];
        logic [38:0] exp_we[$];
        int          a0;
        int          s0;

        vecs[0] = '{8'hFF, 32'h12345678, 1, 32'h06000000, 1'b1};
        vecs[1] = '{8'h0F, 32'h0,        4, 32'h12345777, 1'b0};
        vecs[2] = '{8'h05, 32'h0,        4, 32'hDEADC0DE, 1'b0};
        vecs[3] = '{8'hA0, 32'hCAFEBABE, 1, 32'h06000000, 1'b1};
        vecs[4] = '{8'h20, 32'h0,        4, 32'hDEADC0DE, 1'b0};
        vecs[5] = '{8'h7F, 32'h0,        4, 32'h12345678, 1'b0};

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_busy  = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk12);
        check_reset_outputs("reset");
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Directed table
        for (int i = 0; i < 6; i++) begin
            clear_logs();
            push_cmd(vecs[i].cmd, vecs[i].data);
            wait_tx(vecs[i].ntx, 2000, $sformatf("vec%0d_tx_count", i));
            t = vecs[i].exp_tx;
            for (int b = 0; b < vecs[i].ntx; b++) begin
                if (b < txlog.size())
                    check($sformatf("vec%0d_tx_byte%0d", i, b), txlog[b], t[31-8*b -: 8]);
            end
            check($sformatf("vec%0d_we_count", i), welog.size(), vecs[i].is_wr ? 1 : 0);
            if (vecs[i].is_wr && welog.size() != 0)
                check($sformatf("vec%0d_we_addr_data", i), welog[0], {vecs[i].cmd[6:0], vecs[i].data});
            check($sformatf("vec%0d_addr", i), bus.addr, vecs[i].cmd[6:0]);
            settle();
        end
        model_tmp = 32'h12345678;

        // Timeout on a partial write
        clear_logs();
        timeout_cnt = 0;
        rxq.push_back(8'hFF);
        rxq.push_back(8'hAA);
        begin
            int k = 0;
            while (timeout_cnt == 0 && k < int'(TMO) + 60) begin
                tick();
                k++;
            end
        end
        repeat (5) tick();
        check("timeout_pulses", timeout_cnt, 1);
        check("timeout_delay", timeout_cyc - last_ack_cyc, TMO);
        check("timeout_no_we", welog.size(), 0);
        check("timeout_partial_wdat", bus.wdat, 32'hFEBABEAA);
        clear_logs();
        push_cmd(8'h0F, 32'h0);
        wait_tx(4, 2000, "post_timeout_tx_count");
        t = model_tmp + 32'hFF;
        for (int b = 0; b < 4; b++)
            if (b < txlog.size()) check($sformatf("post_timeout_byte%0d", b), txlog[b], t[31-8*b -: 8]);
        settle();

        // Backpressure mid-read with a pending command byte
        clear_logs();
        push_cmd(8'h0F, 32'h0);
        wait_tx(1, 2000, "bp_first_byte");
        hold_busy = 1'b1;
        push_cmd(8'h05, 32'h0);
        a0 = ack_cnt;
        s0 = send_cnt;
        repeat (500) tick();
        check("bp_no_ack", ack_cnt - a0, 0);
        check("bp_no_send", send_cnt - s0, 0);
        hold_busy = 1'b0;
        wait_tx(8, 3000, "bp_tx_count");
        t = model_tmp + 32'hFF;
        for (int b = 0; b < 8; b++) begin
            if (b == 4) t = 32'hDEADC0DE;
            if (b < txlog.size()) check($sformatf("bp_byte%0d", b), txlog[b], t[31-8*(b%4) -: 8]);
        end
        check("bp_no_we", welog.size(), 0);
        settle();

        // Reset during the second read reply byte
        clear_logs();
        push_cmd(8'h0F, 32'h0);
        wait_tx(2, 2000, "rst_pre_tx");
        rst = 1'b1;
        @(posedge clk12);
        @(negedge clk12);
        check_reset_outputs("midrst");
        tick();
        rst = 1'b0;
        settle();
        clear_logs();
        push_cmd(8'hFF, 32'h00000001);
        wait_tx(1, 2000, "rst_write_tx");
        if (txlog.size() != 0) check("rst_write_ack", txlog[0], 8'h06);
        check("rst_write_we_count", welog.size(), 1);
        if (welog.size() != 0) check("rst_write_we", welog[0], {7'h7F, 32'h00000001});
        model_tmp = 32'h00000001;
        settle();

        // Randomized command stream against transaction-level model
        clear_logs();
        for (int i = 0; i < 25; i++) begin
            logic [6:0]  a;
            logic [31:0] d;
            logic        wr;
            logic [31:0] v;
            case ($urandom_range(0, 3))
                0:       a = 7'h7F;
                1:       a = 7'h0F;
                2:       a = 7'h05;
                default: a = 7'($urandom);
            endcase
            wr = 1'($urandom);
            d  = $urandom;
            push_cmd({wr, a}, d);
            if (wr) begin
                exp_we.push_back({a, d});
                exp_q.push_back(8'h06);
                if (a == 7'h7F) model_tmp = d;
            end else begin
                v = (a == 7'h7F) ? model_tmp : (a == 7'h0F) ? model_tmp + 32'hFF : 32'hDEADC0DE;
                for (int b = 3; b >= 0; b--) exp_q.push_back(v[b*8 +: 8]);
            end
        end
        wait_tx(exp_q.size(), exp_q.size() * 40 + 1000, "rand_tx_count");
        for (int i = 0; i < exp_q.size(); i++)
            if (i < txlog.size()) check($sformatf("rand_tx%0d", i), txlog[i], exp_q[i]);
        check("rand_we_count", welog.size(), exp_we.size());
        for (int i = 0; i < exp_we.size(); i++)
            if (i < welog.size()) check($sformatf("rand_we%0d", i), welog[i], exp_we[i]);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
